// File: rtl/window_3x3_gen_pkg.sv
// Shared image geometry defaults and derived window count for the 3x3 window generator.
package window_3x3_gen_pkg;

    localparam int unsigned IMG_W_DEF     = 320;
    localparam int unsigned IMG_H_DEF     = 240;
    localparam int unsigned PIX_W_DEF     = 8;
    localparam int unsigned WIN_PER_FRAME = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

    function automatic int unsigned win_count(int unsigned w, int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out stream bundle; slave is the generator's view, master the source/sink's.
interface window_3x3_gen_if
    import window_3x3_gen_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
);
    logic             pix_valid_i;
    logic [PIX_W-1:0] pix_data_i;
    logic             pix_ready_o;
    logic             win_valid_o;
    logic             win_ready_i;
    logic [PIX_W-1:0] win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o;
    logic             win_last_o;

    modport slave (
        input  pix_valid_i, pix_data_i, win_ready_i,
        output pix_ready_o, win_valid_o, win_last_o,
        output win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o
    );

    modport master (
        output pix_valid_i, pix_data_i, win_ready_i,
        input  pix_ready_o, win_valid_o, win_last_o,
        input  win0_o, win1_o, win2_o, win3_o, win4_o, win5_o, win6_o, win7_o, win8_o
    );
endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One image line of pixels: combinational read, synchronous write, same address for both.
module window_3x3_gen_line_buffer #(
    parameter int unsigned DEPTH = 320,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    // No reset: stale contents are masked by the row >= 2 emit rule upstream.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two chained line buffers, a 3x3 shift register
// and a registered window output with valid/ready handshake.
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    window_3x3_gen_if.slave  bus
);
    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic             win_valid_q, win_last_q;
    logic [PIX_W-1:0] win_q [9];
    logic [PIX_W-1:0] sr_q  [3][3];
    logic [PIX_W-1:0] sr_d  [3][3];
    logic [PIX_W-1:0] lb_a_rd, lb_b_rd;
    logic             pix_ready, accept, emit, col_end, row_end;

    window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb_a (
        .clk   (clk_i),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb_b_rd),
        .rdata (lb_a_rd)
    );

    window_3x3_gen_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(CW)) u_lb_b (
        .clk   (clk_i),
        .we    (accept),
        .addr  (col_q),
        .wdata (bus.pix_data_i),
        .rdata (lb_b_rd)
    );

    always_comb begin
        pix_ready = !win_valid_q || bus.win_ready_i;
        accept    = bus.pix_valid_i && pix_ready;
        col_end   = (col_q == CW'(IMG_W - 1));
        row_end   = (row_q == RW'(IMG_H - 1));
        emit      = (row_q >= RW'(2)) && (col_q >= CW'(2));
        // Shift left; the new right column is {row-2, row-1, current} at this column.
        for (int r = 0; r < 3; r++) begin
            sr_d[r][0] = sr_q[r][1];
            sr_d[r][1] = sr_q[r][2];
        end
        sr_d[0][2] = lb_a_rd;
        sr_d[1][2] = lb_b_rd;
        sr_d[2][2] = bus.pix_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) sr_q[r][c] <= '0;
            end
        end else if (accept) begin
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
            sr_q        <= sr_d;
            win_valid_q <= emit;
            win_last_q  <= emit && row_end && col_end;
            if (emit) begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) win_q[r*3+c] <= sr_d[r][c];
                end
            end
        end else if (bus.win_ready_i) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end
    end

    assign bus.pix_ready_o = pix_ready;
    assign bus.win_valid_o = win_valid_q;
    assign bus.win_last_o  = win_last_q;
    assign bus.win0_o      = win_q[0];
    assign bus.win1_o      = win_q[1];
    assign bus.win2_o      = win_q[2];
    assign bus.win3_o      = win_q[3];
    assign bus.win4_o      = win_q[4];
    assign bus.win5_o      = win_q[5];
    assign bus.win6_o      = win_q[6];
    assign bus.win7_o      = win_q[7];
    assign bus.win8_o      = win_q[8];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: a 5x4 instance and a 320x240 instance share one stimulus,
// outputs of the selected instance are checked against a frame-level window model.
module tb_window_3x3_gen;
    import window_3x3_gen_pkg::*;

    typedef struct {
        logic [71:0] p;
        bit          last;
    } win_t;

    typedef struct {
        int          after;
        logic [71:0] p;
        bit          last;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pv, wr;
    logic [7:0] pd;
    bit         sel;

    always #5 clk = ~clk;

    window_3x3_gen_if #(.PIX_W(8)) bus_s ();
    window_3x3_gen_if #(.PIX_W(8)) bus_l ();

    assign bus_s.pix_valid_i = pv;
    assign bus_s.pix_data_i  = pd;
    assign bus_s.win_ready_i = wr;
    assign bus_l.pix_valid_i = pv;
    assign bus_l.pix_data_i  = pd;
    assign bus_l.win_ready_i = wr;

    window_3x3_gen #(.IMG_W(5), .IMG_H(4), .PIX_W(8)) dut_s (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_s)
    );

    window_3x3_gen #(.IMG_W(320), .IMG_H(240), .PIX_W(8)) dut_l (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_l)
    );

    logic       rdy, wv, wl;
    logic [7:0] w [9];

    always_comb begin
        rdy  = sel ? bus_l.pix_ready_o : bus_s.pix_ready_o;
        wv   = sel ? bus_l.win_valid_o : bus_s.win_valid_o;
        wl   = sel ? bus_l.win_last_o  : bus_s.win_last_o;
        w[0] = sel ? bus_l.win0_o : bus_s.win0_o;
        w[1] = sel ? bus_l.win1_o : bus_s.win1_o;
        w[2] = sel ? bus_l.win2_o : bus_s.win2_o;
        w[3] = sel ? bus_l.win3_o : bus_s.win3_o;
        w[4] = sel ? bus_l.win4_o : bus_s.win4_o;
        w[5] = sel ? bus_l.win5_o : bus_s.win5_o;
        w[6] = sel ? bus_l.win6_o : bus_s.win6_o;
        w[7] = sel ? bus_l.win7_o : bus_s.win7_o;
        w[8] = sel ? bus_l.win8_o : bus_s.win8_o;
    end

    int tests = 0;
    int fails = 0;

    logic [7:0] frame_img [$];
    logic [7:0] pix_q [$];
    win_t       exp_q [$];

    int          gap_pct, stall_pct, force_stall;
    int          win_cnt, last_cnt, acc_cnt, first_acc, stall_cycles;
    bit          first_seen, held_valid, held_l;
    logic [71:0] held_p, seventh_p;

    int tbl_after [6]    = '{12, 13, 14, 17, 18, 19};
    int tbl_pix   [6][9] = '{'{0, 1, 2, 5, 6, 7, 10, 11, 12},
                             '{1, 2, 3, 6, 7, 8, 11, 12, 13},
                             '{2, 3, 4, 7, 8, 9, 12, 13, 14},
                             '{5, 6, 7, 10, 11, 12, 15, 16, 17},
                             '{6, 7, 8, 11, 12, 13, 16, 17, 18},
                             '{7, 8, 9, 12, 13, 14, 17, 18, 19}};
    bit tbl_last  [6]    = '{0, 0, 0, 0, 0, 1};
    int b2b_first [9]    = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [71:0] get_win();
        logic [71:0] r;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = w[k];
        return r;
    endfunction

    // Frame image: mode 0 = index, 1 = index+100, 2 = random.
    task automatic new_frame(input int wd, input int ht, input int mode);
        frame_img.delete();
        for (int k = 0; k < wd * ht; k++) begin
            if (mode == 0)      frame_img.push_back(8'(k));
            else if (mode == 1) frame_img.push_back(8'(k + 100));
            else                frame_img.push_back(8'($urandom_range(255)));
        end
    endtask

    // Queue the first n pixels and every interior window whose bottom-right lies among them.
    task automatic push_frame(input int wd, input int ht, input int n);
        win_t e;
        for (int k = 0; k < n; k++) pix_q.push_back(frame_img[k]);
        for (int r = 0; r <= ht - 3; r++) begin
            for (int c = 0; c <= wd - 3; c++) begin
                if ((r + 2) * wd + c + 2 < n) begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.p[(i*3+j)*8 +: 8] = frame_img[(r + i) * wd + c + j];
                    e.last = (r == ht - 3) && (c == wd - 3);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pv = 1'b0;
        wr = 1'b0;
        pd = 8'h00;
        pix_q.delete();
        exp_q.delete();
        win_cnt = 0; last_cnt = 0; acc_cnt = 0; first_acc = -1;
        stall_cycles = 0; first_seen = 0; held_valid = 0; force_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_win();
        win_t e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_window: got %0h expected none", get_win());
        end else begin
            e = exp_q.pop_front();
            chk("window", {7'd0, wl, get_win()}, {7'd0, e.last, e.p});
        end
        if (win_cnt == 6) seventh_p = get_win();
        win_cnt++;
        if (wl) last_cnt++;
        if (!first_seen) begin
            first_seen = 1;
            first_acc  = acc_cnt;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        pv = (pix_q.size() > 0) && ($urandom_range(99) >= gap_pct);
        pd = (pix_q.size() > 0) ? pix_q[0] : 8'h00;
        if (force_stall > 0 && wv) begin
            wr = 1'b0;
            force_stall--;
        end else begin
            wr = ($urandom_range(99) >= stall_pct);
        end
        #1;
        if (held_valid) chk("hold", {7'd0, wv, wl, get_win()}, {7'd0, 1'b1, held_l, held_p});
        held_valid = 0;
        if (wv && !wr) begin
            chk("stall_ready", 80'(rdy), 80'(0));
            held_valid = 1;
            held_p = get_win();
            held_l = wl;
            stall_cycles++;
        end
        if (wv && wr) check_win();
        if (pv && rdy) begin
            void'(pix_q.pop_front());
            acc_cnt++;
        end
    endtask

    task automatic run(input int bound);
        int n = 0;
        while ((pix_q.size() > 0 || exp_q.size() > 0) && n < bound) begin
            cycle();
            n++;
        end
        if (n >= bound) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d pixels and %0d windows outstanding, expected 0",
                     pix_q.size(), exp_q.size());
        end
        repeat (3) cycle();
    endtask

    initial begin
        logic [71:0] b2b_p;
        bit          expv;
        int          vi, t1_wins;

        for (int v = 0; v < 6; v++) begin
            vecs[v].after = tbl_after[v];
            for (int k = 0; k < 9; k++) vecs[v].p[k*8 +: 8] = 8'(tbl_pix[v][k]);
            vecs[v].last = tbl_last[v];
        end
        for (int k = 0; k < 9; k++) b2b_p[k*8 +: 8] = 8'(b2b_first[k]);
        gap_pct = 0; stall_pct = 0; sel = 0;
        rst_n = 1'b0; pv = 1'b0; wr = 1'b0; pd = 8'h00;

        // Reset state on both instances, win_ready low so pix_ready relies on win_valid alone.
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            repeat (3) @(negedge clk);
            #1;
            chk("rst_ready", 80'(rdy), 80'(1));
            chk("rst_valid_last", {78'd0, wv, wl}, 80'(0));
            chk("rst_window", 80'(get_win()), 80'(0));
        end

        // Table-driven 5x4 index frame, one pixel per cycle, win_ready high.
        sel = 0;
        do_reset();
        t1_wins = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            pv = (k < 20);
            pd = 8'(k);
            wr = 1'b1;
            #1;
            expv = 0;
            vi = 0;
            for (int v = 0; v < 6; v++) begin
                if (vecs[v].after == k - 1) begin
                    expv = 1;
                    vi = v;
                end
            end
            chk("t1_valid", 80'(wv), 80'(expv));
            if (wv) t1_wins++;
            if (expv) chk("t1_window", {7'd0, wl, get_win()}, {7'd0, vecs[vi].last, vecs[vi].p});
        end
        chk("t1_count", 80'(t1_wins), 80'(6));

        // 5x4 frame with a 3-cycle stall on the first window.
        do_reset();
        new_frame(5, 4, 0);
        push_frame(5, 4, 20);
        gap_pct = 0; stall_pct = 0; force_stall = 3;
        run(200);
        chk("stall_count", 80'(win_cnt), 80'(6));
        chk("stall_last", 80'(last_cnt), 80'(1));
        chk("stall_cycles", 80'(stall_cycles), 80'(3));

        // Two back-to-back 5x4 frames with gaps and downstream back-pressure.
        do_reset();
        new_frame(5, 4, 0);
        push_frame(5, 4, 20);
        new_frame(5, 4, 1);
        push_frame(5, 4, 20);
        gap_pct = 30; stall_pct = 30;
        run(500);
        chk("b2b_count", 80'(win_cnt), 80'(12));
        chk("b2b_first", 80'(seventh_p), 80'(b2b_p));

        // Several random 5x4 frames, no gap between them.
        do_reset();
        for (int f = 0; f < 4; f++) begin
            new_frame(5, 4, 2);
            push_frame(5, 4, 20);
        end
        gap_pct = 25; stall_pct = 25;
        run(1000);
        chk("rand_small_count", 80'(win_cnt), 80'(24));
        chk("rand_small_last", 80'(last_cnt), 80'(4));

        // 320x240: 700 pixels, reset mid-frame, then a full random frame with input gaps.
        sel = 1;
        do_reset();
        new_frame(320, 240, 2);
        push_frame(320, 240, 700);
        gap_pct = 0; stall_pct = 0;
        run(1000);
        do_reset();
        new_frame(320, 240, 2);
        push_frame(320, 240, 320 * 240);
        gap_pct = 3; stall_pct = 0;
        run(90000);
        chk("full_first_after", 80'(first_acc), 80'(643));
        chk("full_count", 80'(win_cnt), 80'(WIN_PER_FRAME));
        chk("full_last", 80'(last_cnt), 80'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
